reg_writeback: RTL and testbench

Writeback-side driver for the pipeline register file: accepts retired results from the MEM stage over a valid/ready handshake, selects and extends load data, buffers pending writes, and sequences the register file write port (`Wen`, `Rd_addr`, `write_data`). The register file commits a write on the rising edge of `Wen`, so this block presents address and data one cycle before strobing `Wen`. It also provides forwarding lookups so decode sees buffered writes that have not yet committed.

---
 rtl/wb_pkg.sv | 29 ++
 rtl/wb_fifo.sv | 63 ++++++
 rtl/reg_writeback.sv | 164 ++++++++++++++++
 tb/tb_reg_writeback.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback register-file driver.
//   wb_state_e : write-port sequencer states
//   LB..LWU    : MEM-stage load funct3 codes
//   wb_entry_t : one pending register write {rd, data}
package wb_pkg;

  // Data width carried by wb_entry_t; reg_writeback's XLEN must match it.
  localparam int unsigned WB_XLEN = 64;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe
  } wb_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of pending register writes with asynchronous active-high reset.
// Ports:
//   clk, reset        : clock, async reset (empties the FIFO)
//   push, wdata       : enqueue (ignored when full)
//   pop, rdata        : dequeue / head entry (pop ignored when empty)
//   full, empty       : occupancy flags
//   ent_valid/ent_data: every entry in age order, index 0 = oldest
module wb_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = logic
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  entry_t           wdata,
  input  logic             pop,
  output entry_t           rdata,
  output logic             full,
  output logic             empty,
  output logic [DEPTH-1:0] ent_valid,
  output entry_t           ent_data [DEPTH]
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  entry_t          mem_q [DEPTH];
  logic            do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage needs no reset: contents are only observed through ent_valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ent_data[k]  = mem_q[rd_ptr_q + PtrW'(k)];
      ent_valid[k] = (CntW'(k) < count_q);
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback-side driver for the register file write port. Accepts retired MEM-stage results,
// extends load data, queues writes and sequences the port so address/data lead rf_wen by a cycle.
// Ports:
//   clk, reset                 : clock, async active-high reset
//   in_valid/in_ready          : MEM-stage handshake (in_ready = FIFO not full)
//   in_reg_write, in_rd        : write enable / destination (rd=0 or no-write is dropped)
//   in_mem_to_reg, in_funct3   : data source select and load extension code
//   in_alu_result, in_mem_data : candidate write data
//   rf_wen/rf_rd_addr/rf_write_data : register file write port
//   fwd_rsN_addr/hit/data      : forwarding lookup of not-yet-committed writes
module reg_writeback
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_reg_write,
  input  logic            in_mem_to_reg,
  input  logic [2:0]      in_funct3,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_mem_data,
  output logic            rf_wen,
  output logic [4:0]      rf_rd_addr,
  output logic [XLEN-1:0] rf_write_data,
  input  logic [4:0]      fwd_rs1_addr,
  input  logic [4:0]      fwd_rs2_addr,
  output logic            fwd_rs1_hit,
  output logic            fwd_rs2_hit,
  output logic [XLEN-1:0] fwd_rs1_data,
  output logic [XLEN-1:0] fwd_rs2_data
);

  typedef struct packed {
    logic            hit;
    logic [XLEN-1:0] data;
  } fwd_t;

  wb_state_e        state_q, state_d;
  wb_entry_t        hold_q, hold_d;
  logic             wen_q, wen_d;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  wb_entry_t        fifo_wdata, fifo_head;
  logic [DEPTH-1:0] ent_valid;
  wb_entry_t        ent_data [DEPTH];
  logic [XLEN-1:0]  load_ext;
  fwd_t             fwd1, fwd2;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready && in_reg_write && (in_rd != 5'd0);

  always_comb begin
    load_ext = in_mem_data;
    case (in_funct3)
      LB:      load_ext = {{(XLEN-8){in_mem_data[7]}}, in_mem_data[7:0]};
      LH:      load_ext = {{(XLEN-16){in_mem_data[15]}}, in_mem_data[15:0]};
      LW:      load_ext = {{(XLEN-32){in_mem_data[31]}}, in_mem_data[31:0]};
      LBU:     load_ext = {{(XLEN-8){1'b0}}, in_mem_data[7:0]};
      LHU:     load_ext = {{(XLEN-16){1'b0}}, in_mem_data[15:0]};
      LWU:     load_ext = {{(XLEN-32){1'b0}}, in_mem_data[31:0]};
      default: load_ext = in_mem_data;  // LD and 3'b111 pass through
    endcase
  end

  assign fifo_wdata = '{rd: in_rd, data: in_mem_to_reg ? load_ext : in_alu_result};

  wb_fifo #(
    .DEPTH  (DEPTH),
    .entry_t(wb_entry_t)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .wdata    (fifo_wdata),
    .pop      (fifo_pop),
    .rdata    (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .ent_valid(ent_valid),
    .ent_data (ent_data)
  );

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    wen_d    = 1'b0;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hold_d   = fifo_head;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        wen_d   = 1'b1;
        state_d = StStrobe;
      end
      StStrobe: begin
        // Reload on the falling strobe edge to sustain one write every two cycles.
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hold_d   = fifo_head;
          state_d  = StSetup;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      hold_q  <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      wen_q   <= wen_d;
    end
  end

  assign rf_wen        = wen_q;
  assign rf_rd_addr    = hold_q.rd;
  assign rf_write_data = hold_q.data;

  // Oldest candidate first so the youngest match overwrites; the hold entry only counts
  // in SETUP because once strobed the register file already has it.
  function automatic fwd_t fwd_lookup(input logic [4:0] addr);
    fwd_t r;
    r = '0;
    if (addr != 5'd0) begin
      if (state_q == StSetup && hold_q.rd == addr) begin
        r.hit  = 1'b1;
        r.data = hold_q.data;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (ent_valid[k] && ent_data[k].rd == addr) begin
          r.hit  = 1'b1;
          r.data = ent_data[k].data;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    fwd1 = fwd_lookup(fwd_rs1_addr);
    fwd2 = fwd_lookup(fwd_rs2_addr);
  end

  assign fwd_rs1_hit  = fwd1.hit;
  assign fwd_rs1_data = fwd1.data;
  assign fwd_rs2_hit  = fwd2.hit;
  assign fwd_rs2_data = fwd2.data;

endmodule

// File: tb/tb_reg_writeback.sv
// Randomised plus directed bench for reg_writeback. The driver pushes each expected register
// write into a queue; a monitor pops on every rf_wen rise and also checks forwarding against
// the list of writes that have not yet been strobed.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_reg_write, in_mem_to_reg;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [63:0] in_alu_result, in_mem_data;
  logic        rf_wen;
  logic [4:0]  rf_rd_addr;
  logic [63:0] rf_write_data;
  logic [4:0]  fwd_rs1_addr, fwd_rs2_addr;
  logic        fwd_rs1_hit, fwd_rs2_hit;
  logic [63:0] fwd_rs1_data, fwd_rs2_data;

  reg_writeback #(.XLEN(64), .DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_reg_write (in_reg_write),
    .in_mem_to_reg(in_mem_to_reg),
    .in_funct3    (in_funct3),
    .in_rd        (in_rd),
    .in_alu_result(in_alu_result),
    .in_mem_data  (in_mem_data),
    .rf_wen       (rf_wen),
    .rf_rd_addr   (rf_rd_addr),
    .rf_write_data(rf_write_data),
    .fwd_rs1_addr (fwd_rs1_addr),
    .fwd_rs2_addr (fwd_rs2_addr),
    .fwd_rs1_hit  (fwd_rs1_hit),
    .fwd_rs2_hit  (fwd_rs2_hit),
    .fwd_rs1_data (fwd_rs1_data),
    .fwd_rs2_data (fwd_rs2_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          rises_cnt = 0;
  int          rise_cyc[$];
  bit          saw_full = 0;
  logic [63:0] regs[32];
  logic        prev_wen = 1'b0;
  logic [4:0]  prev_addr = '0;
  logic [63:0] prev_data = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference write value straight from the load-width rules.
  function automatic logic [63:0] model(input logic m2r, input logic [2:0] f3,
                                        input logic [63:0] alu, input logic [63:0] mem);
    int w;
    logic [63:0] v;
    if (!m2r) return alu;
    case (f3[1:0])
      2'd0: w = 8;
      2'd1: w = 16;
      2'd2: w = 32;
      default: return mem;
    endcase
    v = mem & ((64'd1 << w) - 64'd1);
    if (!f3[2] && mem[w-1]) v = v - (64'd1 << w);
    return v;
  endfunction

  // Forwarding expectation: newest not-yet-strobed write to addr.
  task automatic fwd_model(input logic [4:0] addr, output logic hit, output logic [63:0] data);
    hit = 1'b0;
    data = '0;
    if (addr != 5'd0) begin
      foreach (sb[i]) begin
        if (sb[i].rd == addr) begin
          hit = 1'b1;
          data = sb[i].data;
        end
      end
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    logic        eh;
    logic [63:0] ed;
    exp_t        e;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        sb.delete();
        prev_wen = 1'b0;
        continue;
      end
      if (!in_ready) saw_full = 1'b1;
      if (rf_wen) check("wen_width", prev_wen, 1'b0);
      if (rf_wen && !prev_wen) begin
        rises_cnt++;
        rise_cyc.push_back(cyc);
        regs[rf_rd_addr] = rf_write_data;
        check("addr_stable", rf_rd_addr, prev_addr);
        check("data_stable", rf_write_data, prev_data);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got rd=%0d data=%h want no write", rf_rd_addr,
                   rf_write_data);
        end else begin
          e = sb.pop_front();
          check("wr_rd", rf_rd_addr, e.rd);
          check("wr_data", rf_write_data, e.data);
        end
      end
      fwd_model(fwd_rs1_addr, eh, ed);
      check("fwd1_hit", fwd_rs1_hit, eh);
      check("fwd1_data", fwd_rs1_data, ed);
      fwd_model(fwd_rs2_addr, eh, ed);
      check("fwd2_hit", fwd_rs2_hit, eh);
      check("fwd2_data", fwd_rs2_data, ed);
      prev_wen  = rf_wen;
      prev_addr = rf_rd_addr;
      prev_data = rf_write_data;
    end
  end

  // Offer one transfer, holding in_valid until accepted; returns at posedge+2.
  task automatic xfer(input logic rw, input logic m2r, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [63:0] alu, input logic [63:0] mem,
                      input logic [63:0] expd, output logic acc);
    in_valid      = 1'b1;
    in_reg_write  = rw;
    in_mem_to_reg = m2r;
    in_funct3     = f3;
    in_rd         = rd;
    in_alu_result = alu;
    in_mem_data   = mem;
    acc = 1'b0;
    for (int w = 0; w < 50; w++) begin
      #1;
      acc = in_ready;
      @(posedge clk);
      if (acc) break;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL xfer_timeout: got in_ready=0 want accept within 50 cycles");
    end
    if (acc && rw && rd != 5'd0) sb.push_back('{rd: rd, data: expd});
    #2;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || rf_wen) && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    check({name, "_drained"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic        acc;
    logic [2:0]  f3;
    logic [63:0] alu, mem;
    logic [4:0]  rd;
    logic        rw, m2r;
    logic [63:0] ld_exp [5];
    logic [2:0]  ld_f3 [5];

    foreach (regs[i]) regs[i] = '0;
    reset = 1'b1;
    in_valid = 0; in_reg_write = 0; in_mem_to_reg = 0; in_funct3 = 0; in_rd = 0;
    in_alu_result = 0; in_mem_data = 0; fwd_rs1_addr = 0; fwd_rs2_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wen", rf_wen, 0);
    check("rst_addr", rf_rd_addr, 0);
    check("rst_data", rf_write_data, 0);
    check("rst_ready", in_ready, 1);
    check("rst_hit1", fwd_rs1_hit, 0);
    check("rst_hit2", fwd_rs2_hit, 0);
    check("rst_fdata1", fwd_rs1_data, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #2;

    // Basic write with edge-accurate latency.
    xfer(1, 0, 3'd0, 5'd5, 64'h1234, 64'h0, 64'h1234, acc);
    @(posedge clk); #1;
    check("basic_n1_addr", rf_rd_addr, 5);
    check("basic_n1_data", rf_write_data, 64'h1234);
    check("basic_n1_wen", rf_wen, 0);
    @(posedge clk); #1;
    check("basic_n2_wen", rf_wen, 1);
    @(posedge clk); #1;
    check("basic_n3_wen", rf_wen, 0);
    check("basic_x5", regs[5], 64'h1234);
    #1;
    drain("basic");

    // Load extension table.
    ld_f3  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
    ld_exp = '{64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_0080, 64'hFFFF_FFFF_8000_0080,
               64'h0000_0000_0000_0080, 64'h0000_0000_8000_0080};
    for (int i = 0; i < 5; i++)
      xfer(1, 1, ld_f3[i], 5'(10 + i), 64'hDEAD_BEEF, 64'hFFFF_FFFF_8000_0080, ld_exp[i], acc);
    drain("loadext");

    // Dropped transfers: x0 target and no-write.
    rises_cnt = 0;
    fwd_rs1_addr = 5'd7;
    xfer(1, 0, 3'd0, 5'd0, 64'h55, 64'h0, 64'h55, acc);
    check("x0_ready", acc, 1);
    xfer(0, 0, 3'd0, 5'd7, 64'h66, 64'h0, 64'h66, acc);
    check("nowr_ready", acc, 1);
    check("nowr_hit", fwd_rs1_hit, 0);
    repeat (6) @(posedge clk);
    #2;
    check("drop_no_wen", rises_cnt, 0);

    // Back-to-back burst against backpressure.
    rises_cnt = 0;
    rise_cyc.delete();
    saw_full = 0;
    for (int i = 1; i <= 8; i++) xfer(1, 0, 3'd0, 5'(i), 64'h100 + 64'(i), 64'h0,
                                      64'h100 + 64'(i), acc);
    check("bp_full_seen", saw_full, 1);
    drain("bp");
    check("bp_count", rises_cnt, 8);
    if (rise_cyc.size() == 8)
      for (int i = 1; i < 8; i++) check("bp_spacing", rise_cyc[i] - rise_cyc[i-1], 2);

    // Forwarding priority and commit cut-off.
    fwd_rs1_addr = 5'd3;
    fwd_rs2_addr = 5'd0;
    xfer(1, 0, 3'd0, 5'd3, 64'hA, 64'h0, 64'hA, acc);
    xfer(1, 0, 3'd0, 5'd3, 64'hB, 64'h0, 64'hB, acc);
    check("fp_hit", fwd_rs1_hit, 1);
    check("fp_data", fwd_rs1_data, 64'hB);
    check("fp_x0_hit", fwd_rs2_hit, 0);
    @(posedge clk); #1;
    check("fp_n2_data", fwd_rs1_data, 64'hB);
    @(posedge clk); #1;
    check("fp_hold_hit", fwd_rs1_hit, 1);
    check("fp_hold_data", fwd_rs1_data, 64'hB);
    @(posedge clk); #1;
    check("fp_commit_hit", fwd_rs1_hit, 0);
    #1;
    drain("fp");

    // Reset in STROBE with two entries still queued.
    fwd_rs1_addr = 5'd11;
    xfer(1, 0, 3'd0, 5'd10, 64'h10, 64'h0, 64'h10, acc);
    xfer(1, 0, 3'd0, 5'd11, 64'h11, 64'h0, 64'h11, acc);
    xfer(1, 0, 3'd0, 5'd12, 64'h12, 64'h0, 64'h12, acc);
    check("mr_strobe", rf_wen, 1);
    reset = 1'b1;
    sb.delete();
    #1;
    check("mr_wen", rf_wen, 0);
    check("mr_addr", rf_rd_addr, 0);
    check("mr_data", rf_write_data, 0);
    check("mr_ready", in_ready, 1);
    check("mr_hit1", fwd_rs1_hit, 0);
    check("mr_fdata1", fwd_rs1_data, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    rises_cnt = 0;
    repeat (12) @(posedge clk);
    #1;
    check("mr_no_writes", rises_cnt, 0);
    #1;

    // Random traffic against the reference model.
    for (int i = 0; i < 120; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        repeat (gap) @(posedge clk);
        #2;
      end
      fwd_rs1_addr = 5'($urandom_range(0, 7));
      fwd_rs2_addr = 5'($urandom_range(0, 7));
      rw  = ($urandom_range(0, 7) != 0);
      m2r = 1'($urandom);
      f3  = 3'($urandom);
      rd  = 5'($urandom_range(0, 7));
      alu = {$urandom, $urandom};
      mem = {$urandom, $urandom};
      xfer(rw, m2r, f3, rd, alu, mem, model(m2r, f3, alu, mem), acc);
    end
    drain("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
